// File: rtl/alu_iter.sv
// alu_iter: handshaked, width-parametrised ALU with an iterative shifter.
//
// The 16 operations run at any WIDTH. Non-shift results are registered and
// appear one cycle after acceptance. Shifts move at most SHIFT_STEP bits per
// cycle, so the latency is 1 + ceil(amount / SHIFT_STEP).
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Valid must not depend on ready. Data is sampled only on that edge.
// in_ready depends only on the state and on out_ready.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     request handshake
//   in_a, in_b, in_oper     operands and opcode; in_b[AMT_W-1:0] is the shift amount
//   out_valid / out_ready   result handshake
//   out_data                registered result, held while stalled
//   busy                    high while a shift is iterating
//   dbg_state_o             current FSM state, for debug and checkers
module alu_iter #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam logic [AMT_W:0] STEP = (AMT_W+1)'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLTU = 4'd2,  OP_SLTS = 4'd3;
    localparam logic [3:0] OP_SGTU = 4'd4,  OP_SGTS = 4'd5,  OP_ANDN = 4'd6,  OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8,  OP_XOR  = 4'd9,  OP_NOR  = 4'd10, OP_LSL  = 4'd11;
    localparam logic [3:0] OP_LSR  = 4'd12, OP_ASR  = 4'd13, OP_ORN  = 4'd14, OP_NAND = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   data_q;   // result register; also the shift working value
    logic [AMT_W-1:0]   rem_q;    // shift bits still to apply
    logic [3:0]         op_q;     // shift kind captured at acceptance

    logic               accept;
    logic               is_shift;
    logic [AMT_W-1:0]   amt;
    logic [WIDTH-1:0]   alu_res;
    logic [AMT_W:0]     rem_ext;
    logic [AMT_W:0]     step;
    logic [AMT_W:0]     rem_diff;
    logic [AMT_W-1:0]   rem_next;
    logic [WIDTH-1:0]   shift_res;

    assign out_data    = data_q;
    assign out_valid   = (state_q == ST_DONE);
    assign busy        = (state_q == ST_SHIFT);
    assign dbg_state_o = state_q;

    // In DONE, a new request is taken only while the result is being handed off.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign amt      = in_b[AMT_W-1:0];
    assign is_shift = (in_oper == OP_LSL) || (in_oper == OP_LSR) || (in_oper == OP_ASR);

    // Single-cycle result. A shift by 0 returns a unchanged.
    always_comb begin
        alu_res = '0;
        case (in_oper)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_SLTS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SGTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a > in_b)};
            OP_SGTS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) > $signed(in_b))};
            OP_ANDN: alu_res = in_a & ~in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_ORN:  alu_res = in_a | ~in_b;
            OP_NAND: alu_res = ~(in_a & in_b);
            default: alu_res = in_a;
        endcase
    end

    // One shift iteration: move by min(SHIFT_STEP, remaining).
    // The remaining amount is always below WIDTH, so the step fits in AMT_W bits.
    always_comb begin
        rem_ext  = {1'b0, rem_q};
        step     = (rem_ext > STEP) ? STEP : rem_ext;
        rem_diff = rem_ext - step;
        rem_next = rem_diff[AMT_W-1:0];
        case (op_q)
            OP_LSL:  shift_res = data_q << step;
            OP_LSR:  shift_res = data_q >> step;
            default: shift_res = WIDTH'($signed(data_q) >>> step);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_shift && (amt != '0)) begin
                            data_q  <= in_a;
                            rem_q   <= amt;
                            op_q    <= in_oper;
                            state_q <= ST_SHIFT;
                        end else begin
                            data_q  <= alu_res;
                            state_q <= ST_DONE;
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    data_q <= shift_res;
                    rem_q  <= rem_next;
                    if (rem_next == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

  localparam int W = 32;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [3:0]    in_oper = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  alu_iter #(.WIDTH(W), .SHIFT_STEP(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_oper(in_oper),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: results and latency straight from the operation rules
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int amt;
    amt = int'(b % W);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return (a < b) ? 1 : 0;
      4'd3:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd4:  return (a > b) ? 1 : 0;
      4'd5:  return ($signed(a) > $signed(b)) ? 1 : 0;
      4'd6:  return a & ~b;
      4'd7:  return a & b;
      4'd8:  return a | b;
      4'd9:  return a ^ b;
      4'd10: return ~(a | b);
      4'd11: return a << amt;
      4'd12: return a >> amt;
      4'd13: return W'($signed(a) >>> amt);
      4'd14: return a | ~b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
    int amt;
    amt = int'(b % W);
    if (op >= 4'd11 && op <= 4'd13 && amt != 0) return 1 + (amt + S - 1) / S;
    return 1;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver: issue one request at a negedge, wait for its result, check it.
  // Returns at the negedge where out_valid was first seen.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_d, input int exp_lat, input logic rdy, input string name);
    int guard, lat, busy_cnt, bad_ready;
    out_ready = rdy;
    in_oper = op; in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    check({name, " accept_timeout"}, 32'(guard >= 50), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_oper = 4'($urandom_range(0, 15));
    lat = 0; busy_cnt = 0; bad_ready = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (busy && in_ready) bad_ready++;
    end while (!out_valid && lat < 100);
    check({name, " data"}, out_data, exp_d);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({name, " ready_while_busy"}, 32'(bad_ready), 0);
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_d;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  initial begin
    logic [W-1:0] held, ra, rb;
    logic [3:0] rop;
    int cnt;

    vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, "add_wrap"});
    vecs.push_back('{4'd1,  32'h0,         32'h1,         32'hFFFF_FFFF, 1, "sub_wrap"});
    vecs.push_back('{4'd2,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, "sltu"});
    vecs.push_back('{4'd3,  32'hFFFF_FFFF, 32'h1,         32'h1,         1, "slts"});
    vecs.push_back('{4'd4,  32'hFFFF_FFFF, 32'h1,         32'h1,         1, "sgtu"});
    vecs.push_back('{4'd5,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, "sgts"});
    vecs.push_back('{4'd5,  32'h7FFF_FFFF, 32'h8000_0000, 32'h1,         1, "sgts_extreme"});
    vecs.push_back('{4'd6,  32'hF0F0,      32'h00FF,      32'hF000,      1, "andn"});
    vecs.push_back('{4'd14, 32'h0,         32'hFFFF_FFFE, 32'h1,         1, "orn"});
    vecs.push_back('{4'd7,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, "and"});
    vecs.push_back('{4'd8,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1, "or"});
    vecs.push_back('{4'd9,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1, "xor"});
    vecs.push_back('{4'd10, 32'h0,         32'h0,         32'hFFFF_FFFF, 1, "nor"});
    vecs.push_back('{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1, "nand"});
    vecs.push_back('{4'd13, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 9, "asr_31"});
    vecs.push_back('{4'd11, 32'h1,         32'h25,        32'h20,        3, "lsl_5"});
    vecs.push_back('{4'd12, 32'h1234_5678, 32'h0,         32'h1234_5678, 1, "lsr_0"});
    vecs.push_back('{4'd12, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 2, "lsr_4_upper_b"});
    vecs.push_back('{4'd13, 32'h8000_0000, 32'd4,         32'hF800_0000, 2, "asr_4"});
    vecs.push_back('{4'd11, 32'h1,         32'd31,        32'h8000_0000, 9, "lsl_31"});
    vecs.push_back('{4'd12, 32'hFFFF_FFFF, 32'd3,         32'h1FFF_FFFF, 2, "lsr_3"});

    // reset state
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", out_data, 0);
    check("reset in_ready", 32'(in_ready), 1);
    check("reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed table
    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].lat, 1'b1, vecs[i].name);

    // backpressure, then handoff and acceptance in the same cycle
    out_ready = 1'b1;
    @(negedge clk);
    do_op(4'd0, 32'd3, 32'd4, 32'd7, 1, 1'b0, "stall_add");
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall out_valid", 32'(out_valid), 1);
      check("stall out_data", out_data, 32'd7);
      check("stall in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_oper = 4'd9; in_a = 32'hAA; in_b = 32'hFF;
    #1;
    check("handoff in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("handoff out_valid", 32'(out_valid), 1);
    check("handoff xor data", out_data, 32'h55);
    @(negedge clk);

    // throughput: four back-to-back adds, four consecutive results
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_oper = 4'd0;
      in_a = 32'(100 * i); in_b = 32'(i + 1);
      exp_q.push_back(ref_alu(4'd0, in_a, in_b));
      @(negedge clk);
      check("thru out_valid", 32'(out_valid), 1);
      check("thru out_data", out_data, exp_q.pop_front());
    end
    in_valid = 1'b0;
    @(negedge clk);

    // reset in the middle of a long shift
    in_valid = 1'b1; in_oper = 4'd11; in_a = 32'h1; in_b = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 0);
    check("midreset in_ready", 32'(in_ready), 1);
    check("midreset busy", 32'(busy), 0);
    check("midreset out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("no stale result", 32'(cnt), 0);
    do_op(4'd0, 32'd2, 32'd3, 32'd5, 1, 1'b1, "post_reset_add");

    // randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      do_op(rop, ra, rb, ref_alu(rop, ra, rb), ref_lat(rop, rb), 1'b1, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
Parametrised, handshaked successor to the single-cycle 32-bit ALU. It supports the same 16-operation set at arbitrary data width. All results are registered. Shifts run iteratively, SHIFT_STEP bits per cycle, which trades latency for area in place of a full barrel shifter. It sits between decode/issue and writeback, and a multi-cycle op stalls issue through valid/ready.

Parameters:
WIDTH, 32, data width of a, b and result; must be ≥ 2 and a power of 2.
SHIFT_STEP, 4, maximum bits shifted per cycle; power of 2, 1 ≤ SHIFT_STEP ≤ WIDTH.
(derived) AMT_W = clog2(WIDTH), the shift-amount width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request valid
in_ready  out  1  unit can accept a request this cycle
in_a  in  WIDTH  operand a (shift data)
in_b  in  WIDTH  operand b; low AMT_W bits are the shift amount
in_oper  in  4  operation code
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  result
busy  out  1  high in SHIFT state

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). Reset forces state IDLE and clears out_valid, out_data and all internal registers to 0. Reset mid-operation aborts the operation, and no result is produced.
- Opcodes: 0 Add, 1 Sub, 2 Sltu, 3 Slts, 4 Sgtu, 5 Sgts, 6 AndN (a&~b), 7 And, 8 Or, 9 Xor, 10 Nor, 11 Lsl, 12 Lsr, 13 Asr, 14 OrN (a|~b), 15 Nand.
- Arithmetic: Add and Sub wrap modulo 2^WIDTH, with no flags. Compare ops return 1 or 0, zero-extended to WIDTH. Signed compares treat operands as two's complement.
- Shifts: amount = in_b[AMT_W-1:0]; upper bits of b are ignored. Lsl and Lsr zero-fill. Asr replicates a[WIDTH-1].
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: shift in progress; busy=1, in_ready=0, out_valid=0.
  - DONE: out_valid=1.
- IDLE transitions:
  - Non-shift op accepted (in_valid & in_ready): result registered; go to DONE next cycle. Latency is 1 cycle.
  - Shift op accepted with amount 0: out_data=a; go to DONE next cycle.
  - Shift op accepted with amount > 0: capture a, remaining=amount, op; go to SHIFT.
- SHIFT: each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining by that value. When remaining reaches 0, go to DONE. Total latency from acceptance to out_valid is 1 + ceil(amount/SHIFT_STEP).
- DONE:
  - out_data is held stable while out_valid & !out_ready.
  - in_ready = out_ready in DONE, so result handoff and a new acceptance occur in the same cycle. The unit then proceeds exactly as from IDLE, giving back-to-back single-cycle ops at full throughput.
  - out_ready & !in_valid: go to IDLE, out_valid drops the next cycle.
- in_* is sampled only on acceptance. Changes to in_* while not accepted are ignored.
- in_ready is combinational from state and out_ready only; it never depends on in_valid.
- Unused state encoding: recover to IDLE.

Test Plan:
Add with a=0xFFFF_FFFF, b=1 (WIDTH=32) -> out_data=0x0000_0000, out_valid 1 cycle after accept; Sub with a=0, b=1 -> 0xFFFF_FFFF.
a=0xFFFF_FFFF, b=1: Sltu->0, Slts->1, Sgtu->1, Sgts->0; AndN with a=0xF0F0, b=0x00FF -> 0xF000; OrN with a=0, b=0xFFFF_FFFE -> 0x0000_0001.
Asr with a=0x8000_0000, b=31, SHIFT_STEP=4 -> busy for 8 cycles, out_valid at cycle 9, out_data=0xFFFF_FFFF; Lsl with a=1, b=0x25 (amount 5) -> 0x20 at latency 3; Lsr with b=0 -> a returned at latency 1.
Backpressure: out_ready held low 5 cycles after a result -> out_data stable and in_ready low throughout. Then out_ready=1 with in_valid=1 (Xor, a=0xAA, b=0xFF) -> handoff and acceptance in the same cycle; 0x55 valid on the next cycle.
Throughput: 4 consecutive Add requests with out_ready=1 constantly -> 4 results on 4 consecutive cycles.
Reset: assert rst_n=0 during cycle 3 of a 31-bit Lsl -> out_valid=0 and in_ready=1 immediately after release. A following Add of 2+3 -> 5, with no stale shift result emitted.
